// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types and constants for the CPU clock-enable sequencer.
package cpu_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DIV = 250000;

endpackage

// File: rtl/ce_rate_counter.sv
// Divisor register and rate counter; match is high when the count reaches the divisor.
module ce_rate_counter #(
    parameter int unsigned DIV_WIDTH   = 20,
    parameter int unsigned DEFAULT_DIV = 250000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] value,
    output logic                 match
);

    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] count;

    assign match = (count == div_reg);

    // A divisor load restarts the count so the new rate applies from the load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            div_reg <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (load) begin
            div_reg <= value;
            count   <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= match ? '0 : count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Clock-enable sequencer: stop, free-run at a divided rate, single-step and halt for the core.
module cpu_clock_ctrl #(
    parameter int unsigned DIV_WIDTH   = 20,
    parameter int unsigned DEFAULT_DIV = cpu_clock_ctrl_pkg::DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt,
    input  logic                 resume,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 cpu_ce,
    output logic [31:0]          ce_count,
    output logic [1:0]           state
);

    import cpu_clock_ctrl_pkg::*;

    state_t cur_state;
    state_t next_state;
    logic   ce_next;
    logic   cnt_en;
    logic   cnt_clr;
    logic   match;

    ce_rate_counter #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_rate (
        .clk    (clk),
        .reset  (reset),
        .enable (cnt_en),
        .clear  (cnt_clr),
        .load   (div_load),
        .value  (div_value),
        .match  (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            cpu_ce    <= 1'b0;
            ce_count  <= '0;
        end else begin
            cur_state <= next_state;
            cpu_ce    <= ce_next;
            if (ce_next) begin
                ce_count <= ce_count + 32'd1;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        ce_next    = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        unique case (cur_state)
            IDLE: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (run_req) begin
                    next_state = RUN;
                    cnt_clr    = 1'b1;
                end else if (step_req) begin
                    next_state = STEP;
                    ce_next    = 1'b1;
                end
            end
            RUN: begin
                // Halt suppresses a coincident match; a divisor load also wins over the match.
                if (halt) begin
                    next_state = HALTED;
                    cnt_clr    = 1'b1;
                end else if (!run_req) begin
                    next_state = IDLE;
                end else begin
                    cnt_en  = 1'b1;
                    ce_next = match && !div_load;
                end
            end
            STEP: begin
                next_state = IDLE;
            end
            HALTED: begin
                if (resume && !halt) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign state = cur_state;

endmodule
